cmd_issuer: RTL and testbench

- Initiator end of the command byte protocol: converts one high-level request into a framed command byte sequence on a byte-strobe interface (Command + one-cycle valid, the same shape a command reader consumes).
- Then collects the response bytes, with a timeout.
- Used as on-chip self-test host and as the bench driver for the command reader path.
- Sits between a request source (debug core or test sequencer) and the UART TX byte loader / loopback mux.

---
 rtl/cmd_pkg.sv | 58 +++++
 rtl/cmd_byte_tx.sv | 66 ++++++
 rtl/cmd_issuer.sv | 192 +++++++++++++++++++
 tb/tb_cmd_issuer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared definitions for the command byte protocol (issuer and reader side):
// opcodes, ack byte, FSM encodings and response lengths.
package cmd_pkg;

  typedef enum logic [1:0] {
    OP_SET_THRESHOLD = 2'd0,
    OP_SET_FREQUENCY = 2'd1,
    OP_READ_MAX      = 2'd2,
    OP_READ_CHANNEL  = 2'd3
  } op_e;

  localparam logic [7:0] OPC_SET_THRESHOLD = 8'h54;
  localparam logic [7:0] OPC_SET_FREQUENCY = 8'h46;
  localparam logic [7:0] OPC_READ_MAX      = 8'h4D;
  localparam logic [7:0] OPC_READ_CHANNEL  = 8'h43;
  localparam logic [7:0] ACK_BYTE          = 8'h06;

  localparam logic [1:0] RESP_LEN_WRITE = 2'd1;
  localparam logic [1:0] RESP_LEN_READ  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_OP   = 3'd1,
    ST_SEND_ARG  = 3'd2,
    ST_SEND_CHK  = 3'd3,
    ST_WAIT_RESP = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_GAP  = 1'b1
  } tx_state_e;

  function automatic logic [7:0] opcode_byte(input op_e op);
    logic [7:0] b;
    case (op)
      OP_SET_THRESHOLD: b = OPC_SET_THRESHOLD;
      OP_SET_FREQUENCY: b = OPC_SET_FREQUENCY;
      OP_READ_MAX:      b = OPC_READ_MAX;
      OP_READ_CHANNEL:  b = OPC_READ_CHANNEL;
      default:          b = OPC_SET_THRESHOLD;
    endcase
    return b;
  endfunction

  // Read ops carry one extra response byte when the check byte is enabled.
  function automatic logic [1:0] resp_len(input op_e op, input logic chk_en);
    logic [1:0] n;
    if (op == OP_READ_MAX || op == OP_READ_CHANNEL) begin
      n = chk_en ? (RESP_LEN_READ + 2'd1) : RESP_LEN_READ;
    end else begin
      n = RESP_LEN_WRITE;
    end
    return n;
  endfunction

endpackage

// File: rtl/cmd_byte_tx.sv
// Single command byte handshake: waits for Tx_Ready, strobes the byte for one
// cycle, then counts out the inter-byte gap and pulses done_o at its end.
module cmd_byte_tx
  import cmd_pkg::*;
#(
  parameter int GAP_CYCLES = 16,
  parameter int CNT_W      = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_i,
  input  logic [7:0] byte_i,
  input  logic       tx_ready_i,
  output logic [7:0] cmd_o,
  output logic       cmd_valid_o,
  output logic       done_o
);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobe is combinational on Tx_Ready so the byte goes out in the ready cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_o       = 8'h00;
    cmd_valid_o = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (send_i && tx_ready_i) begin
          cmd_o       = byte_i;
          cmd_valid_o = 1'b1;
          cnt_d       = CNT_W'(GAP_CYCLES);
          state_d     = TX_GAP;
        end else begin
          state_d = TX_IDLE;
        end
      end
      TX_GAP: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          done_o  = 1'b1;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = TX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/cmd_issuer.sv
// cmd_issuer: turns one request into a framed command byte sequence and collects
// the response with a per-byte timeout. Define CMD_ISSUER_CHECKSUM_EN for the XOR check byte + chk_err.
module cmd_issuer
  import cmd_pkg::*;
#(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_arg,
  output logic        req_ready,
  output logic [7:0]  Command,
  output logic        Cmd_Valid,
  input  logic        Tx_Ready,
  input  logic [7:0]  Resp_Byte,
  input  logic        Resp_Valid,
  output logic [15:0] resp_data,
  output logic        done,
`ifdef CMD_ISSUER_CHECKSUM_EN
  output logic        timeout_err,
  output logic        chk_err
`else
  output logic        timeout_err
`endif
);

`ifdef CMD_ISSUER_CHECKSUM_EN
  localparam logic CHK_EN = 1'b1;
  logic chk_q, chk_d;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [7:0]       arg_q, arg_d;
  logic [15:0]      resp_q, resp_d;
  logic             tmo_q, tmo_d;
  logic [1:0]       rcv_q, rcv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_send_s, tx_done_s;
  logic [7:0]       tx_byte_s;

  cmd_byte_tx #(
    .GAP_CYCLES(GAP_CYCLES),
    .CNT_W     (CNT_W)
  ) u_byte_tx (
    .clk        (clk),
    .reset      (reset),
    .send_i     (tx_send_s),
    .byte_i     (tx_byte_s),
    .tx_ready_i (Tx_Ready),
    .cmd_o      (Command),
    .cmd_valid_o(Cmd_Valid),
    .done_o     (tx_done_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_SET_THRESHOLD;
      arg_q   <= 8'h00;
      resp_q  <= 16'h0000;
      tmo_q   <= 1'b0;
      rcv_q   <= 2'd0;
      cnt_q   <= '0;
`ifdef CMD_ISSUER_CHECKSUM_EN
      chk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      resp_q  <= resp_d;
      tmo_q   <= tmo_d;
      rcv_q   <= rcv_d;
      cnt_q   <= cnt_d;
`ifdef CMD_ISSUER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    arg_d     = arg_q;
    resp_d    = resp_q;
    tmo_d     = tmo_q;
    rcv_d     = rcv_q;
    cnt_d     = cnt_q;
    tx_send_s = 1'b0;
    tx_byte_s = 8'h00;
`ifdef CMD_ISSUER_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = op_e'(req_op);
          arg_d   = req_arg;
          resp_d  = 16'h0000;
          tmo_d   = 1'b0;
          rcv_d   = 2'd0;
`ifdef CMD_ISSUER_CHECKSUM_EN
          chk_d   = 1'b0;
`endif
          state_d = ST_SEND_OP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND_OP: begin
        tx_send_s = 1'b1;
        tx_byte_s = opcode_byte(op_q);
        if (tx_done_s) begin
          state_d = ST_SEND_ARG;
        end else begin
          state_d = ST_SEND_OP;
        end
      end
      ST_SEND_ARG: begin
        tx_send_s = 1'b1;
        tx_byte_s = arg_q;
        if (tx_done_s) begin
`ifdef CMD_ISSUER_CHECKSUM_EN
          state_d = ST_SEND_CHK;
`else
          cnt_d   = CNT_W'(TIMEOUT_CYCLES);
          state_d = ST_WAIT_RESP;
`endif
        end else begin
          state_d = ST_SEND_ARG;
        end
      end
      ST_SEND_CHK: begin
        tx_send_s = 1'b1;
        tx_byte_s = opcode_byte(op_q) ^ arg_q;
        if (tx_done_s) begin
          cnt_d   = CNT_W'(TIMEOUT_CYCLES);
          state_d = ST_WAIT_RESP;
        end else begin
          state_d = ST_SEND_CHK;
        end
      end
      // A byte arriving in the counter's last cycle wins over the timeout.
      ST_WAIT_RESP: begin
        if (Resp_Valid) begin
          rcv_d = rcv_q + 2'd1;
`ifdef CMD_ISSUER_CHECKSUM_EN
          if (rcv_q == 2'd2) begin
            chk_d = (Resp_Byte != (resp_q[15:8] ^ resp_q[7:0]));
          end else begin
            resp_d = {resp_q[7:0], Resp_Byte};
          end
`else
          resp_d = {resp_q[7:0], Resp_Byte};
`endif
          if (rcv_d == resp_len(op_q, CHK_EN)) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = CNT_W'(TIMEOUT_CYCLES);
          end
        end else if (cnt_q <= CNT_W'(1)) begin
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign resp_data   = resp_q;
  assign timeout_err = tmo_q;
`ifdef CMD_ISSUER_CHECKSUM_EN
  assign chk_err     = chk_q;
`endif

endmodule

// File: tb/tb_cmd_issuer.sv
// Scoreboard bench for cmd_issuer: driver pushes expected command bytes and
// completions, a negedge monitor pops and compares them.
module tb_cmd_issuer;

  localparam int GAP = 5;
  localparam int TMO = 100;
  localparam int CW  = 17;
`ifdef CMD_ISSUER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, Cmd_Valid, Tx_Ready, Resp_Valid, done, timeout_err;
  logic [1:0]  req_op;
  logic [7:0]  req_arg, Command, Resp_Byte;
  logic [15:0] resp_data;
`ifdef CMD_ISSUER_CHECKSUM_EN
  logic        chk_err;
`endif

  always #5 clk = ~clk;

  cmd_issuer #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_arg(req_arg),
    .req_ready(req_ready), .Command(Command), .Cmd_Valid(Cmd_Valid), .Tx_Ready(Tx_Ready),
    .Resp_Byte(Resp_Byte), .Resp_Valid(Resp_Valid), .resp_data(resp_data), .done(done),
`ifdef CMD_ISSUER_CHECKSUM_EN
    .timeout_err(timeout_err), .chk_err(chk_err)
`else
    .timeout_err(timeout_err)
`endif
  );

  typedef struct packed { logic [7:0] b; logic first; } cmd_t;
  typedef struct packed { logic [15:0] data; logic tmo; logic chk; int nrx; } cmp_t;

  cmd_t cmd_q[$];
  cmp_t cmp_q[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   first_due = -1, tmo_due = -1, last_strobe = 0;
  bit   tx_rand = 1'b0, ready_pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] opc(input int op);
    case (op)
      0: return 8'h54;
      1: return 8'h46;
      2: return 8'h4D;
      default: return 8'h43;
    endcase
  endfunction

  // Random link back-pressure.
  initial forever begin
    @(posedge clk); #1;
    if (tx_rand) Tx_Ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: every strobe and every done pulse is matched against the scoreboard.
  initial forever begin
    cmd_t c;
    cmp_t e;
    @(negedge clk);
    if (ready_pending) begin
      check("req_ready_after_done", req_ready, 1);
      ready_pending = 1'b0;
    end
    if (Cmd_Valid) begin
      if (cmd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_cmd: got %0h expected none (cycle %0d)", Command, cyc);
      end else begin
        c = cmd_q.pop_front();
        check("cmd_byte", Command, c.b);
        if (c.first) begin
          if (first_due >= 0) check("first_strobe_cycle", cyc, first_due);
          first_due = -1;
        end else begin
          check("strobe_spacing", (cyc - last_strobe >= GAP + 1), 1);
        end
        last_strobe = cyc;
      end
    end
    if (done) begin
      if (cmp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done expected none (cycle %0d)", cyc);
      end else begin
        e = cmp_q.pop_front();
        check("resp_data", resp_data, e.data);
        check("timeout_err", timeout_err, e.tmo);
`ifdef CMD_ISSUER_CHECKSUM_EN
        check("chk_err", chk_err, e.chk);
`endif
        check("req_ready_low_in_done", req_ready, 0);
        if (e.tmo && e.nrx == 0) check("timeout_cycle_nobyte", cyc, last_strobe + GAP + 1 + TMO);
        else if (e.tmo) check("timeout_cycle", cyc, tmo_due);
        ready_pending = 1'b1;
      end
    end
  end

  // mode: 0 random Tx_Ready, 1 Tx_Ready high, 2 Tx_Ready low for 50 cycles after accept.
  task automatic run_txn(input int op, input logic [7:0] arg, input logic [7:0] b0, b1, b2,
                         input int n, input int mode, input bit late, input bit do_reset);
    logic [7:0]  rb[3];
    logic [15:0] d;
    int          len, plen, k, accept;
    cmd_t        c;
    cmp_t        e;
    rb[0] = b0; rb[1] = b1; rb[2] = b2;
    plen = (op >= 2) ? 2 : 1;
    len  = plen + ((CHK && op >= 2) ? 1 : 0);
    k = 0;
    while (!req_ready && k < 1000) begin @(posedge clk); #1; k++; end
    check("ready_before_req", req_ready, 1);
    if ($urandom_range(0, 2) == 0) begin
      Resp_Byte = 8'($urandom); Resp_Valid = 1'b1;
      @(posedge clk); #1; Resp_Valid = 1'b0;
    end
    c.b = opc(op); c.first = 1'b1; cmd_q.push_back(c);
    c.b = arg;     c.first = 1'b0; cmd_q.push_back(c);
    if (CHK) begin c.b = opc(op) ^ arg; c.first = 1'b0; cmd_q.push_back(c); end
    d = 16'h0000;
    for (int i = 0; i < n && i < plen; i++) d = {d[7:0], rb[i]};
    e.data = d; e.tmo = (n < len); e.nrx = n;
    e.chk  = CHK && (op >= 2) && (n == 3) && (rb[2] != (rb[0] ^ rb[1]));
    if (!do_reset) cmp_q.push_back(e);
    accept = cyc;
    tx_rand = (mode == 0);
    if (mode == 1) begin Tx_Ready = 1'b1; first_due = accept + 1; end
    if (mode == 2) begin Tx_Ready = 1'b0; first_due = accept + 51; end
    req_op = 2'(op); req_arg = arg; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    if (mode == 2) begin
      repeat (50) begin @(posedge clk); #1; end
      Tx_Ready = 1'b1;
    end
    if (do_reset) begin
      k = 0;
      while (cmd_q.size() > (CHK ? 1 : 0) && k < 2000) begin @(posedge clk); #1; k++; end
      check("second_byte_seen", (cmd_q.size() <= (CHK ? 1 : 0)), 1);
      @(posedge clk); #1; @(posedge clk); #1;
      reset = 1'b1; cmd_q.delete();
      @(posedge clk); #1; reset = 1'b0;
      check("rst_cmd_valid", Cmd_Valid, 0);
      check("rst_command", Command, 0);
      check("rst_req_ready", req_ready, 1);
      check("rst_done", done, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_resp_data", resp_data, 0);
      repeat (3 * GAP + 20) @(posedge clk);
      #1;
      return;
    end
    k = 0;
    while (cmd_q.size() != 0 && k < 2000) begin @(posedge clk); #1; k++; end
    if (cmd_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL cmd_timeout: got %0d pending expected 0", cmd_q.size());
      cmd_q.delete();
    end
    for (int i = 0; i < n; i++) begin
      if (i == 0) k = late ? (GAP + TMO - 1) : (GAP + 2 + $urandom_range(0, 20));
      else k = $urandom_range(0, 20);
      repeat (k) begin @(posedge clk); #1; end
      Resp_Byte = rb[i]; Resp_Valid = 1'b1;
      if (i == n - 1) tmo_due = cyc + 1 + TMO;
      @(posedge clk); #1; Resp_Valid = 1'b0;
    end
    k = 0;
    while (cmp_q.size() != 0 && k < 4 * TMO + 200) begin @(posedge clk); #1; k++; end
    if (cmp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got %0d pending expected 0", cmp_q.size());
      cmp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int op, n, len;
    logic [7:0] a0, a1;
    reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_arg = 8'h00;
    Tx_Ready = 1'b1; Resp_Byte = 8'h00; Resp_Valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("init_req_ready", req_ready, 1);
    check("init_cmd_valid", Cmd_Valid, 0);
    check("init_command", Command, 0);
    check("init_resp_data", resp_data, 0);
    check("init_done", done, 0);
    check("init_timeout_err", timeout_err, 0);
`ifdef CMD_ISSUER_CHECKSUM_EN
    check("init_chk_err", chk_err, 0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    run_txn(0, 8'h3C, 8'h06, 8'h00, 8'h00, 1, 1, 0, 0);
    run_txn(3, 8'h02, 8'hA1, 8'h5B, 8'hA1 ^ 8'h5B, CHK ? 3 : 2, 1, 0, 0);
    run_txn(1, 8'h07, 8'h06, 8'h00, 8'h00, 1, 2, 0, 0);
    run_txn(2, 8'h00, 8'h12, 8'h00, 8'h00, 1, 1, 0, 0);
    run_txn(0, 8'h11, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    run_txn(2, 8'h09, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1);
    run_txn(3, 8'h05, 8'hC3, 8'h3C, 8'hFF, CHK ? 3 : 2, 0, 0, 0);
    run_txn(1, 8'h22, 8'h06, 8'h00, 8'h00, 1, 1, 1, 0);
    run_txn(2, 8'h01, 8'h01, 8'h02, 8'h04, CHK ? 3 : 2, 0, 0, 0);
    run_txn(2, 8'h01, 8'h01, 8'h02, 8'h03, CHK ? 3 : 2, 0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      op  = $urandom_range(0, 3);
      len = (op >= 2) ? (CHK ? 3 : 2) : 1;
      n   = ($urandom_range(0, 3) != 0) ? len : $urandom_range(0, len - 1);
      a0  = 8'($urandom); a1 = 8'($urandom);
      run_txn(op, 8'($urandom), a0, a1,
              ($urandom_range(0, 1) != 0) ? (a0 ^ a1) : 8'($urandom),
              n, $urandom_range(0, 1), ($urandom_range(0, 7) == 0), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
